// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder and its store.
//   bus_cmd_e    - processor bus command encodings
//   mem_size_e   - access size
//   dmem_state_e - responder FSM state
//   dmem_req_t   - request captured at acceptance
//   lane_be / lane_data / misaligned - sub-word store helpers
//     (used only when DMEM_SUBWORD_EN is defined)
package dmem_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    bus_cmd_e    cmd;
    logic [31:0] data;  // already replicated onto the target byte lanes
    logic [3:0]  be;
    logic        err;   // out of range or misaligned: ack only, no access
  } dmem_req_t;

  // Little-endian byte-lane enables for a store of the given size.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] ofs);
    case (mem_size_e'(size))
      BYTE:    lane_be = 4'b0001 << ofs;
      HALF:    lane_be = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the low bytes so whichever lane is enabled sees the right data.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (mem_size_e'(size))
      BYTE:    lane_data = {4{data[7:0]}};
      HALF:    lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    case (mem_size_e'(size))
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = ofs[0];
      default: misaligned = (ofs != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word store with byte-write enables.
//   clk, rst      - clock; rst clears only the read register, never the array
//   en, we        - access strobe; we=1 write, we=0 read
//   be[3:0]       - byte-write enables (little-endian lanes)
//   addr[AW-1:0]  - word index
//   wdata, rdata  - write data / registered read data (held between reads)
module dmem_array #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int AW              = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory model for a processor bus.
// Accepts one command in IDLE, waits LATENCY cycles, then pulses ack for one
// cycle (RESP) while the store is read or written. Commands seen while busy
// are dropped.
//   clk, rst              - clock, synchronous active-high reset
//   proc2Dmem_command[1:0]- BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2Dmem_addr[31:0]  - byte address
//   proc2mem_data[31:0]   - store data
//   proc2Dmem_size[1:0]   - BYTE / HALF / WORD
//   mem2proc_data[31:0]   - load data, held until the next good load
//   mem2proc_ack          - one-cycle completion pulse
//   mem2proc_busy         - high in WAIT and RESP
//   mem2proc_error        - with ack: out-of-range (or misaligned) access
// Build option: DMEM_SUBWORD_EN enables byte/half stores; without it size and
// addr[1:0] are ignored and every store writes the whole word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2Dmem_size,
  output logic [31:0] mem2proc_data,
  output logic        mem2proc_ack,
  output logic        mem2proc_busy,
  output logic        mem2proc_error
);

  localparam int         AW       = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e   state, state_nxt;
  logic [3:0]    cnt;
  dmem_req_t     req, req_in, act;
  logic [AW-1:0] widx, widx_in, act_widx;
  logic          accept, fire, arr_en, arr_we;

  assign accept  = (state == IDLE) && (bus_cmd_e'(proc2Dmem_command) != BUS_NONE);
  assign widx_in = proc2Dmem_addr[AW+1:2];

  // Decode the incoming command into what the array access will need.
  always_comb begin
    req_in      = '0;
    req_in.cmd  = bus_cmd_e'(proc2Dmem_command);
    req_in.data = proc2mem_data;
    req_in.be   = 4'hF;
    req_in.err  = (proc2Dmem_addr[31:2] >= 30'(MEM_DEPTH_WORDS));
`ifdef DMEM_SUBWORD_EN
    if (req_in.cmd == BUS_STORE) begin
      req_in.be   = lane_be(proc2Dmem_size, proc2Dmem_addr[1:0]);
      req_in.data = lane_data(proc2Dmem_size, proc2mem_data);
      if (misaligned(proc2Dmem_size, proc2Dmem_addr[1:0])) req_in.err = 1'b1;
    end
`endif
  end

`ifndef DMEM_SUBWORD_EN
  logic unused_subword;
  assign unused_subword = ^{proc2Dmem_size, proc2Dmem_addr[1:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched request and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      req  <= '0;
      widx <= '0;
    end else if (accept) begin
      cnt  <= CNT_LOAD;
      req  <= req_in;
      widx <= widx_in;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt  <= cnt - 4'd1;
    end
  end

  // Next state: leave WAIT on the edge where the count reaches zero so ack
  // lands exactly LATENCY cycles after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt <= 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The array is accessed on the edge that enters RESP. With LATENCY=1 that
  // edge is the accepting one, so the request comes straight from the bus.
  assign fire     = (state_nxt == RESP) && (state != RESP) && !rst;
  assign act      = (state == IDLE) ? req_in  : req;
  assign act_widx = (state == IDLE) ? widx_in : widx;
  assign arr_we   = (act.cmd == BUS_STORE);
  assign arr_en   = fire && !act.err && (act.cmd == BUS_LOAD || act.cmd == BUS_STORE);

  dmem_array #(
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS),
    .AW             (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .en   (arr_en),
    .we   (arr_we),
    .be   (act.be),
    .addr (act_widx),
    .wdata(act.data),
    .rdata(mem2proc_data)
  );

  // Outputs
  always_comb begin
    mem2proc_ack   = 1'b0;
    mem2proc_busy  = 1'b0;
    mem2proc_error = 1'b0;
    case (state)
      WAIT: mem2proc_busy = 1'b1;
      RESP: begin
        mem2proc_busy  = 1'b1;
        mem2proc_ack   = 1'b1;
        mem2proc_error = req.err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized load/store traffic
// against a word-level memory model. A second instance covers LATENCY=1.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int L     = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd, size;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;

  logic [1:0]  cmd1, size1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ack1, busy1, err1;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .proc2Dmem_command(cmd), .proc2Dmem_addr(addr),
    .proc2mem_data(wdata), .proc2Dmem_size(size),
    .mem2proc_data(rdata), .mem2proc_ack(ack),
    .mem2proc_busy(busy), .mem2proc_error(err)
  );

  dmem_responder #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .proc2Dmem_command(cmd1), .proc2Dmem_addr(addr1),
    .proc2mem_data(wdata1), .proc2Dmem_size(size1),
    .mem2proc_data(rdata1), .mem2proc_ack(ack1),
    .mem2proc_busy(busy1), .mem2proc_error(err1)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference: memory as a sparse word map, plus the last good load value.
  logic [31:0] mem_m [int];
  logic [31:0] last_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  function automatic void model(input logic [1:0] c, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] s,
                                output logic e, output logic [31:0] q);
    int w;
    logic [31:0] cur;
    w = int'(a[31:2]);
    e = (a[31:2] >= DEPTH);
`ifdef DMEM_SUBWORD_EN
    if (c == BUS_STORE && ((s == HALF && a[0]) || (s == WORD && a[1:0] != 2'b00))) e = 1'b1;
`endif
    if (!e && c == BUS_STORE) begin
      cur = mem_m.exists(w) ? mem_m[w] : 32'h0;
`ifdef DMEM_SUBWORD_EN
      case (s)
        BYTE:    cur[8*a[1:0] +: 8] = d[7:0];
        HALF:    cur[16*a[1] +: 16] = d[15:0];
        default: cur = d;
      endcase
`else
      cur = d;
`endif
      mem_m[w] = cur;
    end else if (!e && c == BUS_LOAD) begin
      last_q = mem_m.exists(w) ? mem_m[w] : 32'hx;
    end
    q = last_q;
  endfunction

  // One transaction on the LATENCY=L instance. Called just after a posedge;
  // returns just after the posedge that starts the following IDLE cycle.
  task automatic xact(input logic [1:0] c, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] s, input string tag);
    logic e;
    logic [31:0] q;
    int lat;
    model(c, a, d, s, e, q);
    cmd = c; addr = a; wdata = d; size = s;
    @(posedge clk); #1;
    cmd = BUS_NONE;
    lat = 1;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, L);
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_data"}, rdata, q);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nack, first, lastc, seen;
    logic e;
    logic [31:0] q, a;
    logic [1:0] c, s;

    rst = 1'b1;
    cmd = BUS_NONE; addr = '0; wdata = '0; size = WORD;
    cmd1 = BUS_NONE; addr1 = '0; wdata1 = '0; size1 = WORD;
    last_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  rdata,       32'h0);
    chk("rst_ack",   32'(ack),    32'h0);
    chk("rst_busy",  32'(busy),   32'h0);
    chk("rst_err",   32'(err),    32'h0);
    chk("rst1_data", rdata1,      32'h0);
    chk("rst1_busy", 32'(busy1),  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then back-to-back load
    xact(BUS_STORE, 32'h10, 32'hDEADBEEF, WORD, "st10");
    xact(BUS_LOAD,  32'h10, 32'h0,        WORD, "ld10");
    chk("ld10_const", rdata, 32'hDEADBEEF);

    // Out-of-range: word 1024 must error, keep data, and not alias onto word 0
    xact(BUS_LOAD,  32'h1000, 32'h0, WORD, "oob_ld");
    chk("oob_ld_hold", rdata, 32'hDEADBEEF);
    xact(BUS_STORE, 32'h0,    32'h0,        WORD, "clr0");
    xact(BUS_STORE, 32'h1000, 32'h00000BAD, WORD, "oob_st");
    xact(BUS_LOAD,  32'h0,    32'h0,        WORD, "ld0");
    chk("oob_nowrite", rdata, 32'h0);

    // Load held during busy: one ack per L+1 cycles, extras dropped
    model(BUS_LOAD, 32'h10, 32'h0, WORD, e, q);
    cmd = BUS_LOAD; addr = 32'h10; size = WORD;
    nack = 0; first = -1; lastc = -1;
    for (int k = 0; k < 3*(L+1); k++) begin
      @(negedge clk);
      if (ack) begin
        nack++;
        if (first < 0) first = k;
        lastc = k;
      end
    end
    @(posedge clk); #1;
    cmd = BUS_NONE;
    chk("hold_acks",  nack,  3);
    chk("hold_first", first, L);
    chk("hold_last",  lastc, 3*L + 2);
    chk("hold_data",  rdata, q);

    // Reset in WAIT aborts the store
    xact(BUS_STORE, 32'h20, 32'h11111111, WORD, "pre20");
    cmd = BUS_STORE; addr = 32'h20; wdata = 32'h12345678; size = WORD;
    @(posedge clk); #1;
    cmd = BUS_NONE; rst = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack) seen++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack) seen++;
    end
    @(posedge clk); #1;
    chk("abort_ack",  seen,  0);
    chk("abort_data", rdata, 32'h0);
    last_q = 32'h0;
    xact(BUS_LOAD, 32'h20, 32'h0, WORD, "post_rst");
    chk("post_rst_const", rdata, 32'h11111111);

`ifdef DMEM_SUBWORD_EN
    xact(BUS_STORE, 32'h0, 32'h0,  WORD, "sw_clr");
    xact(BUS_STORE, 32'h2, 32'hAB, BYTE, "sw_byte");
    xact(BUS_LOAD,  32'h0, 32'h0,  WORD, "sw_ld");
    chk("sw_ld_const", rdata, 32'h00AB0000);
    xact(BUS_STORE, 32'h1, 32'hFFFF, HALF, "sw_half_mis");
    xact(BUS_LOAD,  32'h0, 32'h0,    WORD, "sw_ld2");
    chk("sw_mis_nowrite", rdata, 32'h00AB0000);
`else
    xact(BUS_STORE, 32'h2, 32'hCAFEF00D, BYTE, "nw_byte");
    xact(BUS_LOAD,  32'h0, 32'h0,        WORD, "nw_ld");
    chk("nw_full_word", rdata, 32'hCAFEF00D);
`endif

    // Random traffic over a 16-word window plus occasional out-of-range hits
    for (int w = 0; w < 16; w++) xact(BUS_STORE, 32'(w*4), $urandom, WORD, "init");
    for (int n = 0; n < 80; n++) begin
      c = 2'($urandom_range(1, 2));
      s = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
      else                           a = 32'($urandom_range(0, 15) * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      xact(c, a, $urandom, s, "rnd");
    end

    // LATENCY=1 instance
    cmd1 = BUS_STORE; addr1 = 32'h40; wdata1 = 32'h5A5A5A5A; size1 = WORD;
    @(posedge clk); #1;
    cmd1 = BUS_NONE;
    @(negedge clk);
    chk("l1_st_ack",  32'(ack1),  32'd1);
    chk("l1_st_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("l1_idle_ack",  32'(ack1),  32'd0);
    chk("l1_idle_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    cmd1 = BUS_LOAD; addr1 = 32'h40;
    @(posedge clk); #1;
    cmd1 = BUS_NONE;
    @(negedge clk);
    chk("l1_ld_ack",  32'(ack1), 32'd1);
    chk("l1_ld_err",  32'(err1), 32'd0);
    chk("l1_ld_data", rdata1,    32'h5A5A5A5A);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
